// File: rtl/i2cs.sv
// i2cs: I2C target (slave), 7-bit addressing, standard/fast mode.
// Decodes START/STOP, the device address, an 8-bit register pointer, write
// data and read requests. A byte-wide local register port lets an external
// register file be written (wr_valid/wr_addr/wr_data) and read
// (rd_addr -> rd_data, combinational).
//
// Parameters:
//   SLV_ADDR  7-bit device address matched against the byte after START.
//   FILT      glitch-filter depth in clk cycles; 0 bypasses the filter.
//
// Optional feature macro: I2CS_GCALL_EN (ACK the general-call address 8'h00).
//
// Ports:
//   clk, rst_n                  system clock (>= 16x SCL), async active-low reset
//   i2c_scl_i/_o/_oe            SCL pad triplet; never driven (no stretching)
//   i2c_sda_i/_o/_oe            SDA pad triplet; open drain, _oe=1 pulls low
//   wr_valid, wr_addr, wr_data  one-clk write strobe per received data byte
//   rd_addr, rd_data            current pointer and the data read from it
//   busy                        addressed: from address match to STOP or re-address
module i2cs #(
  parameter logic [6:0]  SLV_ADDR = 7'h50,
  parameter int unsigned FILT     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl_i,
  output logic       i2c_scl_o,
  output logic       i2c_scl_oe,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam int unsigned CW = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_PTR, S_ACK_P,
    S_WDATA, S_ACK_W, S_TX, S_MACK, S_IGNORE
  } state_e;

  // Two-flop synchronizers; reset to the idle (released) bus level.
  logic [1:0] scl_sync_q, sda_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_scl_i};
      sda_sync_q <= {sda_sync_q[0], i2c_sda_i};
    end
  end

  logic scl_f, sda_f;

  // Stable filter: a new level is accepted only after FILT consecutive clks.
  if (FILT == 0) begin : g_nofilt
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
  end else begin : g_filt
    localparam int unsigned FW = (FILT < 2) ? 1 : $clog2(FILT);
    logic [FW-1:0] scl_cnt_q, sda_cnt_q;
    logic          scl_f_q, sda_f_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        scl_cnt_q <= '0;
        sda_cnt_q <= '0;
        scl_f_q   <= 1'b1;
        sda_f_q   <= 1'b1;
      end else begin
        if (scl_sync_q[1] == scl_f_q) begin
          scl_cnt_q <= '0;
        end else if (scl_cnt_q == FW'(FILT - 1)) begin
          scl_f_q   <= scl_sync_q[1];
          scl_cnt_q <= '0;
        end else begin
          scl_cnt_q <= scl_cnt_q + FW'(1);
        end
        if (sda_sync_q[1] == sda_f_q) begin
          sda_cnt_q <= '0;
        end else if (sda_cnt_q == FW'(FILT - 1)) begin
          sda_f_q   <= sda_sync_q[1];
          sda_cnt_q <= '0;
        end else begin
          sda_cnt_q <= sda_cnt_q + FW'(1);
        end
      end
    end
    assign scl_f = scl_f_q;
    assign sda_f = sda_f_q;
  end

  // Edge detection on the filtered lines.
  logic scl_p_q, sda_p_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_f;
      sda_p_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_f & ~scl_p_q;
  assign scl_fall  = ~scl_f &  scl_p_q;
  assign start_det =  scl_f &  sda_p_q & ~sda_f;
  assign stop_det  =  scl_f & ~sda_p_q &  sda_f;

  state_e        state_q, state_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [6:0]    shift_q, shift_d;
  logic [7:0]    ptr_q, ptr_d;
  logic [7:0]    wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic          sda_oe_q, sda_oe_d, wr_valid_q, wr_valid_d;
  logic          busy_q, busy_d, rw_q, rw_d;

  logic [7:0] rx_byte;
  logic       addr_match;
  assign rx_byte = {shift_q, sda_f};
`ifdef I2CS_GCALL_EN
  assign addr_match = (rx_byte[7:1] == SLV_ADDR) || (rx_byte == 8'h00);
`else
  assign addr_match = (rx_byte[7:1] == SLV_ADDR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  // Protocol FSM: bits sampled on SCL rise, SDA changed on SCL fall.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    if (start_det) begin
      state_d  = S_ADDR;
      sda_oe_d = 1'b0;
      bitcnt_d = '0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      bitcnt_d = '0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte[6:0];
            if (bitcnt_q == CW'(7)) begin
              bitcnt_d = '0;
              if (state_q == S_ADDR) begin
                busy_d  = addr_match;
                rw_d    = rx_byte[0];
                state_d = addr_match ? S_ACK_A : S_IGNORE;
              end else if (state_q == S_PTR) begin
                ptr_d   = rx_byte;
                state_d = S_ACK_P;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = rx_byte;
                state_d    = S_ACK_W;
              end
            end else begin
              bitcnt_d = bitcnt_q + CW'(1);
            end
          end
        end
        // First fall after the byte starts the ACK, the next fall ends it.
        S_ACK_A, S_ACK_P, S_ACK_W: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              bitcnt_d = '0;
              if (state_q == S_ACK_A) begin
                if (rw_q) begin
                  shift_d  = rd_data[6:0];
                  sda_oe_d = ~rd_data[7];
                  state_d  = S_TX;
                end else begin
                  state_d = S_PTR;
                end
              end else begin
                if (state_q == S_ACK_W) ptr_d = ptr_q + 8'd1;
                state_d = S_WDATA;
              end
            end
          end
        end
        // Bit 7 is already on the line at entry; remaining bits follow falls.
        S_TX: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + CW'(1);
          end else if (scl_fall) begin
            if (bitcnt_q == CW'(8)) begin
              sda_oe_d = 1'b0;
              bitcnt_d = '0;
              state_d  = S_MACK;
            end else begin
              sda_oe_d = ~shift_q[6];
              shift_d  = {shift_q[5:0], 1'b0};
            end
          end
        end
        // The pointer advances past every transmitted byte, ACKed or not.
        S_MACK: begin
          if (scl_rise) begin
            ptr_d    = ptr_q + 8'd1;
            bitcnt_d = CW'(1);
            if (sda_f) state_d = S_IGNORE;
          end else if (scl_fall && (bitcnt_q != '0)) begin
            shift_d  = rd_data[6:0];
            sda_oe_d = ~rd_data[7];
            bitcnt_d = '0;
            state_d  = S_TX;
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign i2c_scl_o  = 1'b0;
  assign i2c_scl_oe = 1'b0;
  assign i2c_sda_o  = 1'b0;
  assign i2c_sda_oe = sda_oe_q;
  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_addr    = ptr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2cs.sv
// tb_i2cs: directed bench for the i2cs I2C target. A bit-banged initiator
// drives SCL/SDA; the register file returns rd_addr ^ 8'hFF.
module tb_i2cs;
  localparam int unsigned QT = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       i2c_scl_o, i2c_scl_oe, i2c_sda_o, i2c_sda_oe;
  logic       wr_valid, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       sda_bus;

  assign sda_bus = sda_m & ~i2c_sda_oe;
  assign rd_data = rd_addr ^ 8'hFF;

  i2cs #(.SLV_ADDR(7'h50), .FILT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i2c_scl_i(scl_m), .i2c_scl_o(i2c_scl_o), .i2c_scl_oe(i2c_scl_oe),
    .i2c_sda_i(sda_bus), .i2c_sda_o(i2c_sda_o), .i2c_sda_oe(i2c_sda_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  logic [15:0] wr_log [64];

  always @(negedge clk) begin
    if (wr_valid) begin
      if (wr_cnt < 64) wr_log[wr_cnt] = {wr_addr, wr_data};
      wr_cnt = wr_cnt + 1;
    end
    if (i2c_sda_oe) oe_cnt = oe_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic qwait();
    repeat (QT) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b0; qwait(); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    qwait(); sda_m = 1'b0; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b1; qwait();
  endtask

  task automatic send_bit(input logic b, input logic glitch, output logic smp);
    qwait(); sda_m = b; qwait(); scl_m = 1'b1;
    repeat (4) @(negedge clk);
    if (glitch) begin
      sda_m = ~b; @(negedge clk); sda_m = b;
    end else begin
      @(negedge clk);
    end
    repeat (QT - 5) @(negedge clk);
    smp = sda_bus;
    qwait(); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 0; i < 8; i++) send_bit(b[7-i], logic'(i == glitch_bit), s);
    send_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, 1'b0, s);
      d = {d[6:0], s};
    end
    send_bit(nack, 1'b0, s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (i2c_sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe: got %b expected 0", i2c_sda_oe); end
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
    checks++; if ({wr_addr, wr_data} !== 16'h0000) begin failures++; $display("FAIL reset_wr_bus: got %h expected 0000", {wr_addr, wr_data}); end
    checks++; if (rd_addr !== 8'h00) begin failures++; $display("FAIL reset_rd_addr: got %h expected 00", rd_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({i2c_scl_o, i2c_scl_oe, i2c_sda_o} !== 3'b000) begin failures++; $display("FAIL reset_const_pads: got %b expected 000", {i2c_scl_o, i2c_scl_oe, i2c_sda_o}); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_write();
    logic [3:0] a;
    int base;
    base = wr_cnt;
    i2c_start();
    write_byte(8'hA0, -1, a[3]);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy_set: got %b expected 1", busy); end
    write_byte(8'h10, -1, a[2]);
    write_byte(8'h5A, -1, a[1]);
    write_byte(8'hC3, -1, a[0]);
    i2c_stop();
    repeat (20) @(negedge clk);
    checks++; if (a !== 4'hF) begin failures++; $display("FAIL write_acks: got %b expected 1111", a); end
    checks++; if (wr_cnt - base !== 2) begin failures++; $display("FAIL write_count: got %0d expected 2", wr_cnt - base); end
    checks++; if (wr_log[base] !== 16'h105A) begin failures++; $display("FAIL write_first: got %h expected 105a", wr_log[base]); end
    checks++; if (wr_log[base+1] !== 16'h11C3) begin failures++; $display("FAIL write_second: got %h expected 11c3", wr_log[base+1]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_clr: got %b expected 0", busy); end
    checks++; if (rd_addr !== 8'h12) begin failures++; $display("FAIL write_ptr: got %h expected 12", rd_addr); end
  endtask

  task automatic test_read();
    logic [2:0] a;
    logic [7:0] d0, d1, d2;
    i2c_start();
    write_byte(8'hA0, -1, a[2]);
    write_byte(8'h20, -1, a[1]);
    i2c_start();
    write_byte(8'hA1, -1, a[0]);
    read_byte(1'b0, d0);
    read_byte(1'b0, d1);
    read_byte(1'b1, d2);
    i2c_stop();
    repeat (20) @(negedge clk);
    checks++; if (a !== 3'b111) begin failures++; $display("FAIL read_acks: got %b expected 111", a); end
    checks++; if (d0 !== 8'hDF) begin failures++; $display("FAIL read_byte0: got %h expected df", d0); end
    checks++; if (d1 !== 8'hDE) begin failures++; $display("FAIL read_byte1: got %h expected de", d1); end
    checks++; if (d2 !== 8'hDD) begin failures++; $display("FAIL read_byte2: got %h expected dd", d2); end
    checks++; if (rd_addr !== 8'h23) begin failures++; $display("FAIL read_ptr: got %h expected 23", rd_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL read_busy_clr: got %b expected 0", busy); end
  endtask

  task automatic test_wrong_addr();
    logic [1:0] a;
    int wr0, oe0, busy0;
    wr0 = wr_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
    i2c_start();
    write_byte(8'hA2, -1, a[1]);
    write_byte(8'h55, -1, a[0]);
    i2c_stop();
    repeat (20) @(negedge clk);
    checks++; if (a !== 2'b00) begin failures++; $display("FAIL wrong_acks: got %b expected 00", a); end
    checks++; if (oe_cnt - oe0 !== 0) begin failures++; $display("FAIL wrong_sda_driven: got %0d clks expected 0", oe_cnt - oe0); end
    checks++; if (wr_cnt - wr0 !== 0) begin failures++; $display("FAIL wrong_wr_valid: got %0d expected 0", wr_cnt - wr0); end
    checks++; if (busy_cnt - busy0 !== 0) begin failures++; $display("FAIL wrong_busy: got %0d clks expected 0", busy_cnt - busy0); end
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] a;
    int base;
    base = wr_cnt;
    i2c_start();
    write_byte(8'hA0, -1, a[3]);
    write_byte(8'hFF, -1, a[2]);
    write_byte(8'h11, -1, a[1]);
    write_byte(8'h22, -1, a[0]);
    i2c_stop();
    repeat (20) @(negedge clk);
    checks++; if (a !== 4'hF) begin failures++; $display("FAIL wrap_acks: got %b expected 1111", a); end
    checks++; if (wr_cnt - base !== 2) begin failures++; $display("FAIL wrap_count: got %0d expected 2", wr_cnt - base); end
    checks++; if (wr_log[base] !== 16'hFF11) begin failures++; $display("FAIL wrap_first: got %h expected ff11", wr_log[base]); end
    checks++; if (wr_log[base+1] !== 16'h0022) begin failures++; $display("FAIL wrap_second: got %h expected 0022", wr_log[base+1]); end
  endtask

  task automatic test_glitch_reset();
    logic [3:0] a;
    logic [2:0] c;
    logic s;
    int base;
    base = wr_cnt;
    i2c_start();
    write_byte(8'hA0, -1, a[3]);
    write_byte(8'h30, -1, a[2]);
    write_byte(8'h5A, 1, a[1]);
    write_byte(8'h3C, 0, a[0]);
    checks++; if (a !== 4'hF) begin failures++; $display("FAIL glitch_acks: got %b expected 1111", a); end
    checks++; if (wr_cnt - base !== 2) begin failures++; $display("FAIL glitch_count: got %0d expected 2", wr_cnt - base); end
    checks++; if (wr_log[base] !== 16'h305A) begin failures++; $display("FAIL glitch_first: got %h expected 305a", wr_log[base]); end
    checks++; if (wr_log[base+1] !== 16'h313C) begin failures++; $display("FAIL glitch_second: got %h expected 313c", wr_log[base+1]); end
    for (int i = 0; i < 8; i++) send_bit(((8'h99 >> (7 - i)) & 8'h01) != 8'h00, 1'b0, s);
    qwait(); sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait();
    checks++; if (i2c_sda_oe !== 1'b1) begin failures++; $display("FAIL rst_pre_ack: got %b expected 1", i2c_sda_oe); end
    rst_n = 1'b0;
    #1;
    checks++; if (i2c_sda_oe !== 1'b0) begin failures++; $display("FAIL rst_sda_oe: got %b expected 0", i2c_sda_oe); end
    checks++; if ({busy, wr_valid} !== 2'b00) begin failures++; $display("FAIL rst_busy_wr: got %b expected 00", {busy, wr_valid}); end
    checks++; if (rd_addr !== 8'h00) begin failures++; $display("FAIL rst_ptr: got %h expected 00", rd_addr); end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    base = wr_cnt;
    i2c_start();
    write_byte(8'hA0, -1, c[2]);
    write_byte(8'h40, -1, c[1]);
    write_byte(8'h66, -1, c[0]);
    i2c_stop();
    repeat (20) @(negedge clk);
    checks++; if (c !== 3'b111) begin failures++; $display("FAIL post_rst_acks: got %b expected 111", c); end
    checks++; if (wr_cnt - base !== 1) begin failures++; $display("FAIL post_rst_count: got %0d expected 1", wr_cnt - base); end
    checks++; if (wr_log[base] !== 16'h4066) begin failures++; $display("FAIL post_rst_write: got %h expected 4066", wr_log[base]); end
  endtask

  task automatic test_gcall();
    logic [2:0] a;
    int base;
    base = wr_cnt;
    i2c_start();
    write_byte(8'h00, -1, a[2]);
    write_byte(8'h05, -1, a[1]);
    write_byte(8'h77, -1, a[0]);
    i2c_stop();
    repeat (20) @(negedge clk);
`ifdef I2CS_GCALL_EN
    checks++; if (a !== 3'b111) begin failures++; $display("FAIL gcall_acks: got %b expected 111", a); end
    checks++; if (wr_cnt - base !== 1) begin failures++; $display("FAIL gcall_count: got %0d expected 1", wr_cnt - base); end
    checks++; if (wr_log[base] !== 16'h0577) begin failures++; $display("FAIL gcall_write: got %h expected 0577", wr_log[base]); end
`else
    checks++; if (a !== 3'b000) begin failures++; $display("FAIL gcall_nack: got %b expected 000", a); end
    checks++; if (wr_cnt - base !== 0) begin failures++; $display("FAIL gcall_count: got %0d expected 0", wr_cnt - base); end
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrong_addr();
    test_ptr_wrap();
    test_glitch_reset();
    test_gcall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2cs.md
Name: i2cs

Overview:
- I2C target (slave) for 7-bit addressing, standard/fast mode; the responder counterpart to the team's i2cm initiator.
- Decodes START, address, 8-bit register pointer, write data and read requests from SCL/SDA.
- Exposes a byte-wide local register port so an external register file or RAM can be read and written over I2C.
- Sits beside i2cm on the same open-drain pad wrappers (_i/_o/_oe triplets).

Parameters:
- SLV_ADDR, 7'h50, 7-bit device address matched against the first byte after START.
- FILT, 3, glitch-filter depth in clk cycles on synchronized SCL/SDA; 0 bypasses the filter.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- i2c_scl_i  input  1  SCL pad input.
- i2c_scl_o  output  1  SCL pad output; constant 0.
- i2c_scl_oe  output  1  SCL pad enable; constant 0 (no clock stretching).
- i2c_sda_i  input  1  SDA pad input.
- i2c_sda_o  output  1  SDA pad output; constant 0 (open drain).
- i2c_sda_oe  output  1  1 pulls SDA low.
- wr_valid  output  1  one-clk pulse per received data byte.
- wr_addr  output  8  register address for wr_valid.
- wr_data  output  8  data byte for wr_valid.
- rd_addr  output  8  current pointer; rd_data must be valid combinationally from rd_addr.
- rd_data  input  8  read data from the external register file.
- busy  output  1  high from address match to STOP, or to a START that does not re-address this target.

Behaviour:
- Reset: i2c_sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, state IDLE, pointer=0.
- Input conditioning:
  - 2-FF synchronizer on SCL and SDA, then a FILT-cycle stable filter; edges are detected on the filtered values.
  - Sampling occurs on filtered SCL rise.
  - SDA is driven from 1 clk after filtered SCL fall.
  - Pin-to-action latency is 3+FILT clk.
- Bus conditions:
  - START / repeated START: SDA falls while SCL is high. Enter ADDR from any state; release SDA; clear the bit count.
  - STOP: SDA rises while SCL is high. Enter IDLE from any state; release SDA; busy=0.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first.
    - Bits [7:1]==SLV_ADDR: go to ACK_A and set busy=1.
    - Otherwise: go to IGNORE and leave SDA released.
  - ACK_A: hold SDA low from SCL fall after bit 8 to SCL fall after bit 9.
    - R/W=0: go to PTR.
    - R/W=1: go to TX and load the shift register from rd_data at that SCL fall.
  - PTR: shift 8 bits, load pointer, go to ACK_P (ACK), then WDATA.
  - WDATA: shift 8 bits.
    - On the 8th SCL rise: pulse wr_valid with wr_addr=pointer and wr_data=byte.
    - Go to ACK_W (ACK), increment pointer, return to WDATA.
  - TX: drive SDA low for each 0 bit, MSB first, changing on SCL fall. After 8 bits, release SDA and go to MACK.
  - MACK: sample SDA on the 9th SCL rise.
    - 0 (ACK): increment pointer; on the following SCL fall reload from rd_data and go to TX.
    - 1 (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Pointer behaviour:
  - 8-bit, wraps 8'hFF to 8'h00.
  - Retained across STOP and repeated START, so "write ptr, Sr, read" reads from ptr.
- Writes: a write with only a pointer byte (no data) produces no wr_valid.
- Reset mid-transfer: returns immediately to reset values; SDA is released within the reset assertion.
- Simultaneous START and STOP detection is impossible (one SDA edge per clk); START takes priority if both flags are ever set.

Optional Feature:
- Macro: I2CS_GCALL_EN.
- Defined: address byte 8'h00 (general call, write) is ACKed and busy=1.
  - The following byte is taken as a pointer; subsequent bytes are written as in WDATA.
  - Address byte 8'h01 is NACKed and the target goes to IGNORE.
- Undefined: 8'h00 is treated as an address mismatch (NACK, IGNORE).

Test Plan:
- S, 0xA0, 0x10, 0x5A, 0xC3, P -> ACK on all 4 bytes; wr_valid pulses (0x10,0x5A) then (0x11,0xC3); busy 1 then 0 after P.
- S, 0xA0, 0x20, Sr, 0xA1, read 3 bytes with ACK, ACK, NACK, P; rd_data=rd_addr^0xFF -> bytes 0xDF, 0xDE, 0xDD on SDA; pointer ends 0x23.
- S, 0xA2 (wrong address), 0x55, P -> SDA never driven; no wr_valid; busy stays 0.
- Pointer 0xFF, write 0x11, 0x22 -> wr_addr 0xFF then 0x00.
- 1-clk SDA glitch while SCL is high with FILT=3, and rst_n asserted mid-byte -> no START/STOP is detected from the glitch; after reset, sda_oe=0 and state IDLE; the next clean transaction is ACKed.
- I2CS_GCALL_EN defined: S, 0x00, 0x05, 0x77, P -> ACKs and wr_valid (0x05,0x77); undefined: NACK after 0x00.
